cache_data_wr_ctrl: RTL
=======================

CACHE_DATA_WR_CTRL -- requirements
Module: cache_data_wr_ctrl

Interface
REQ-001 The block SHALL have parameter SETS_W, default 8, meaning the set-index width (256 sets x 4 quarters x 4 ways = 4096 x 128-bit entries).
REQ-002 The block SHALL have these ports, one per line, as name  direction  width  meaning:
  clk1  in  1  sole clock, rising edge.
  rst_n  in  1  asynchronous active-low reset.
  fill_req  in  1  line-fill request; held with its operands until fill_ack.
  fill_index  in  SETS_W  set index of the line.
  fill_way  in  2  destination way.
  fill_data  in  512  full line; quarter q is bits [128q+127:128q].
  fill_ack  out  1  one-cycle pulse on the last beat.
  st_req  in  1  store-hit write request; held with its operands until st_ack.
  st_index  in  SETS_W  set index.
  st_quarter  in  2  quarter within the line.
  st_way  in  2  way.
  st_data  in  128  store data.
  st_ack  out  1  one-cycle pulse on the write cycle.
  bram_wr_en  out  1  data-array write enable.
  bram_wr_addr  out  SETS_W+4  {index, quarter, way}.
  bram_wr_data  out  128  data-array write data.
  fill_active  out  1  high while a fill is in progress, so readers can stall.
  fill_active_index  out  SETS_W  index of the in-progress fill.

Function
REQ-003 The FSM SHALL have states IDLE, FILL and STORE.
REQ-004 In IDLE with only fill_req high in cycle N, the block SHALL capture fill_data, fill_index and fill_way, and enter FILL with beat=0.
REQ-005 In FILL the block SHALL drive bram_wr_en=1, bram_wr_addr={index, beat, way} and bram_wr_data=quarter[beat] in cycles N+1..N+4 for beat 0,1,2,3, incrementing beat each cycle.
REQ-006 fill_ack SHALL pulse in cycle N+4, coincident with beat 3, after which the FSM SHALL return to IDLE.
REQ-007 fill_active SHALL be 1 in cycles N+1..N+4, and fill_active_index SHALL hold the captured index throughout.
REQ-008 In IDLE with only st_req high in cycle N, the block SHALL enter STORE and in cycle N+1 drive bram_wr_en=1, bram_wr_addr={st_index, st_quarter, st_way}, bram_wr_data=st_data, and pulse st_ack.
REQ-009 STORE SHALL always return to IDLE after one cycle.
REQ-010 When fill_req and st_req are both high in IDLE, the block SHALL grant the requester not granted last (round-robin via a last_grant bit).
REQ-011 last_grant SHALL reset to STORE, so that the first contention goes to the fill.
REQ-012 Requests arriving while the FSM is in FILL or STORE SHALL wait; none SHALL be dropped or acknowledged early.
REQ-013 A request that is still high in the IDLE cycle immediately after its own ack SHALL be treated as a new request.
REQ-014 Requesters SHALL deassert in the cycle after ack; this is a protocol rule, not checked by the block.
REQ-015 Fill operands SHALL be registered at grant; changes to fill_* during FILL SHALL have no effect.
REQ-016 Store operands SHALL be registered at grant.
REQ-017 bram_wr_en SHALL be 0 in IDLE and in every cycle with no granted beat.
REQ-018 bram_wr_addr and bram_wr_data SHALL be don't-care whenever bram_wr_en=0.
REQ-019 All outputs SHALL be registered.
REQ-020 Sustained throughput SHALL be one fill per 5 cycles and one store per 2 cycles.
REQ-021 With both requesters continuously active, grants SHALL strictly alternate.

Reset
REQ-022 When rst_n=0 the block SHALL set state=IDLE, beat=0, last_grant=STORE, and drive bram_wr_en, fill_ack, st_ack and fill_active to 0, all asynchronously.
REQ-023 Reset during FILL SHALL abort the fill with no further beats and no ack; already-written quarters remain in the array, and the requester SHALL reissue the fill.
REQ-024 The data array contents SHALL NOT be cleared by this block.

Structure
REQ-025 A shared package cache_pkg SHALL hold SETS_W, LINE_W=512, BEAT_W=128, WAY_W=2, the state enum and the bram address-packing function.
REQ-026 The round-robin arbiter SHALL be a separate sub-module rr_arb2 (2 requests, grant, last_grant register); all other logic is flat.

Verification
REQ-027 Single fill, index=0x12, way=2, data quarters Q0..Q3: writes SHALL occur at addresses 0x122, 0x126, 0x12A, 0x12E in cycles N+1..N+4, with fill_ack at N+4.
REQ-028 Single store, index=0x05, quarter=3, way=1, data=0xDEAD: one write SHALL occur at 0x05D in cycle N+1, with st_ack at N+1 and bram_wr_en low otherwise.
REQ-029 fill_req and st_req rise in the same cycle after reset: the fill SHALL be granted first, then the store in the IDLE cycle after fill_ack.
REQ-030 Both requesters held continuously for 20 cycles: grants SHALL alternate F,S,F,S with no gaps beyond one IDLE cycle.
REQ-031 rst_n low during beat 2 of a fill: no beat-3 write SHALL occur, no fill_ack SHALL pulse, and all outputs SHALL read 0 until the next grant.
REQ-032 fill_data changed mid-FILL: beats written SHALL match the data captured at grant.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache data-array write path.
// Holds the array geometry, the write-controller state encoding, the
// round-robin grant encoding and the helper that packs the low
// {quarter, way} part of a data-array address.
package cache_pkg;
  localparam int SETS_W = 8;    // 256 sets
  localparam int LINE_W = 512;  // one cache line
  localparam int BEAT_W = 128;  // one data-array entry / one fill beat
  localparam int WAY_W  = 2;    // 4 ways
  localparam int QTR_W  = 2;    // 4 quarters per line

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STORE = 2'd2
  } wr_state_e;

  // last_grant encoding; the value doubles as the request/grant bit index
  localparam logic GNT_FILL  = 1'b0;
  localparam logic GNT_STORE = 1'b1;

  // Data-array address is {index, quarter, way}; the index is prepended
  // by the caller so the set width can stay a per-instance parameter.
  function automatic logic [QTR_W+WAY_W-1:0] pack_addr_lo(
    input logic [QTR_W-1:0] quarter,
    input logic [WAY_W-1:0] way
  );
    return {quarter, way};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between line fills and store hits.
// Ports:
//   clk1, rst_n  clock / async active-low reset
//   en           arbitration allowed this cycle (controller idle)
//   req[1:0]     bit 0 = fill, bit 1 = store
//   gnt[1:0]     one-hot grant, combinational, zero when en=0
// On contention the requester not granted last wins; last_grant resets
// to STORE so the first contention goes to the fill.
module rr_arb2
  import cache_pkg::*;
(
  input  logic       clk1,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = (last_grant == GNT_STORE) ? 2'b01 : 2'b10;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)      last_grant <= GNT_STORE;
    else if (gnt[0]) last_grant <= GNT_FILL;
    else if (gnt[1]) last_grant <= GNT_STORE;
  end
endmodule

// File: rtl/cache_data_wr_ctrl.sv
// Cache data-array write controller.
// Serialises 512-bit line fills (four 128-bit beats) and 128-bit store
// hits onto a single data-array write port, with round-robin arbitration
// between the two requesters.
// Ports:
//   clk1, rst_n                     clock / async active-low reset
//   fill_req/index/way/data         fill request, held until fill_ack
//   fill_ack                        pulse with the last fill beat
//   st_req/index/quarter/way/data   store request, held until st_ack
//   st_ack                          pulse with the store write
//   bram_wr_en/addr/data            data-array write port, addr={index,quarter,way}
//   fill_active, fill_active_index  fill in progress and its set, for reader stall
// All outputs are registered: the output comb computes the values for the
// next cycle and a single register stage presents them.
module cache_data_wr_ctrl
  import cache_pkg::*;
#(
  parameter int SETS_W = cache_pkg::SETS_W
)(
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     fill_req,
  input  logic [SETS_W-1:0]        fill_index,
  input  logic [WAY_W-1:0]         fill_way,
  input  logic [LINE_W-1:0]        fill_data,
  output logic                     fill_ack,
  input  logic                     st_req,
  input  logic [SETS_W-1:0]        st_index,
  input  logic [QTR_W-1:0]         st_quarter,
  input  logic [WAY_W-1:0]         st_way,
  input  logic [BEAT_W-1:0]        st_data,
  output logic                     st_ack,
  output logic                     bram_wr_en,
  output logic [SETS_W+QTR_W+WAY_W-1:0] bram_wr_addr,
  output logic [BEAT_W-1:0]        bram_wr_data,
  output logic                     fill_active,
  output logic [SETS_W-1:0]        fill_active_index
);
  localparam int ADDR_W = SETS_W + QTR_W + WAY_W;

  wr_state_e                    state, state_nxt;
  logic [QTR_W-1:0]             beat, beat_nxt;   // beat currently on the write port
  logic [1:0]                   gnt;
  logic [3:0][BEAT_W-1:0]       line_q;
  logic [SETS_W-1:0]            line_idx;
  logic [WAY_W-1:0]             line_way;

  logic                         wr_en_d, fill_ack_d, st_ack_d, fill_active_d;
  logic [ADDR_W-1:0]            wr_addr_d;
  logic [BEAT_W-1:0]            wr_data_d;

  rr_arb2 u_arb (
    .clk1  (clk1),
    .rst_n (rst_n),
    .en    (state == IDLE),
    .req   ({st_req, fill_req}),
    .gnt   (gnt)
  );

  // state register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // next state
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (gnt[0])      state_nxt = FILL;
        else if (gnt[1]) state_nxt = STORE;
      end
      FILL: begin
        if (beat == 2'd3) begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end else begin
          beat_nxt  = beat + 2'd1;
        end
      end
      default: state_nxt = IDLE;  // STORE lasts exactly one cycle
    endcase
  end

  // next-cycle output values; addr/data forced to 0 when no write
  always_comb begin
    wr_en_d       = 1'b0;
    wr_addr_d     = '0;
    wr_data_d     = '0;
    fill_ack_d    = 1'b0;
    st_ack_d      = 1'b0;
    fill_active_d = 1'b0;
    case (state)
      IDLE: begin
        if (gnt[0]) begin
          // beat 0 comes straight from the request; later beats from line_q
          wr_en_d       = 1'b1;
          wr_addr_d     = {fill_index, pack_addr_lo(2'd0, fill_way)};
          wr_data_d     = fill_data[BEAT_W-1:0];
          fill_active_d = 1'b1;
        end else if (gnt[1]) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {st_index, pack_addr_lo(st_quarter, st_way)};
          wr_data_d = st_data;
          st_ack_d  = 1'b1;
        end
      end
      FILL: begin
        if (beat != 2'd3) begin
          wr_en_d       = 1'b1;
          wr_addr_d     = {line_idx, pack_addr_lo(beat_nxt, line_way)};
          wr_data_d     = line_q[beat_nxt];
          fill_active_d = 1'b1;
          fill_ack_d    = (beat_nxt == 2'd3);
        end
      end
      default: ;
    endcase
  end

  // fill operand capture at grant; later changes on fill_* are ignored
  always_ff @(posedge clk1) begin
    if (state == IDLE && gnt[0]) begin
      line_q   <= fill_data;
      line_way <= fill_way;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n)                        line_idx <= '0;
    else if (state == IDLE && gnt[0])  line_idx <= fill_index;
  end

  // output register
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      bram_wr_en   <= 1'b0;
      bram_wr_addr <= '0;
      bram_wr_data <= '0;
      fill_ack     <= 1'b0;
      st_ack       <= 1'b0;
      fill_active  <= 1'b0;
    end else begin
      bram_wr_en   <= wr_en_d;
      bram_wr_addr <= wr_addr_d;
      bram_wr_data <= wr_data_d;
      fill_ack     <= fill_ack_d;
      st_ack       <= st_ack_d;
      fill_active  <= fill_active_d;
    end
  end

  assign fill_active_index = line_idx;
endmodule
